serial_word_fifo: RTL
=====================

// Module: serial_word_fifo
// PURPOSE
//  Bit-serial input word queue. write_in pulses clock data_in bits into a WIDTH-bit
//  deserialiser; each complete word is pushed into a DEPTH-entry circular FIFO
//  (enqueue_in, or automatically); dequeue_in pops the head onto data_out.
//  Parametrised successor of the fixed 8-bit/fixed-depth queue in TOP. Slow
//  button-style strobes are accepted directly. TOP instantiates it as its core.
// PARAMETERS
//  WIDTH      8  bits per word (>=2)
//  DEPTH      8  FIFO entries (power of 2, >=2)
//  MSB_FIRST  1  1: first serial bit lands in data_out[WIDTH-1]; 0: in bit 0
// PORTS
//  clock_1MHz   in   1                  system clock, 1 MHz
//  rst          in   1                  synchronous, active-high reset
//  data_in      in   1                  serial data bit, sampled on write_in rise
//  write_in     in   1                  bit strobe (level, any length)
//  enqueue_in   in   1                  push strobe (level, any length)
//  dequeue_in   in   1                  pop strobe (level, any length)
//  status_out   out  1                  1 = ready for a new serial word
//  data_out     out  WIDTH              last popped word, held until next pop
//  word_rdy_out out  1                  deserialiser holds a complete word
//  full_out     out  1                  count == DEPTH
//  empty_out    out  1                  count == 0
//  count_out    out  $clog2(DEPTH)+1    current FIFO occupancy
//  ovf_out      out  1                  sticky: push attempted while full
// BEHAVIOUR
//  - Reset (rst high at a clock edge): all outputs 0 except empty_out=1, status_out=1;
//    pointers, bit counter and sync/edge flops cleared. Reset mid-word discards bits.
//  - Strobes: each of write_in/enqueue_in/dequeue_in passes a 2-flop synchroniser,
//    then a rising-edge detector; one action per rising edge, however long the level
//    is held. Input rise -> visible register effect after 3 clock edges.
//  - FSM states: IDLE, SHIFT, HOLD.
//    IDLE: bitcnt=0, status_out=1 if !full. write edge -> shift bit, bitcnt=1, SHIFT.
//    SHIFT: write edge shifts bit, bitcnt++; on bit WIDTH -> HOLD, word_rdy_out=1.
//    HOLD: write edges ignored (no overwrite). enqueue edge: if !full push word,
//      -> IDLE; if full, word kept, ovf_out<=1, stay HOLD.
//    status_out = (state==IDLE) && !full_out, registered.
//  - Enqueue edge outside HOLD: ignored, no flag.
//  - Pop: dequeue edge with !empty -> data_out <= mem[rd_ptr], rd_ptr++, count--.
//    Dequeue edge while empty: ignored, data_out held.
//  - Simultaneous push and pop edges same cycle: both performed, count unchanged;
//    legal when full (pop frees entry) -> no ovf; when empty -> pop ignored, push done.
//  - Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH; count saturates 0..DEPTH.
//  - ovf_out clears only on rst.
// CONFIGURATION
//  AUTO_ENQUEUE_EN defined: HOLD pushes automatically on the cycle after entry
//    (same full/ovf rules, retried each cycle while full); enqueue_in is ignored.
//  Undefined: push only on an enqueue_in edge as above.
// STRUCTURE
//  Package serial_fifo_pkg: state_t enum {IDLE,SHIFT,HOLD}; function for
//    pointer/count widths; DEFAULT_WIDTH/DEFAULT_DEPTH constants.
//  Sub-module edge_sync (2-flop sync + rising-edge pulse), 3 instances.
//  FIFO memory: plain register array, one write/one read port, no inferred RAM.
// TESTING
//  1 Reset, send 1000_0000 MSB-first (8 write pulses, 10 cycles each) + enqueue ->
//    count_out=1, status_out=1; dequeue -> data_out=8'h80, empty_out=1.
//  2 Send 4 words 80,81,82,83, pop 4 -> data_out 80,81,82,83 in order, empty_out=1.
//  3 Fill 8 words -> full_out=1, status_out=0; 9th word+enqueue -> ovf_out=1,
//    word_rdy_out stays 1; pop once, enqueue again -> pushed, full_out=1.
//  4 Hold dequeue_in high 200 cycles with 3 words queued -> exactly one pop, count 3->2.
//  5 rst after 5 of 8 bits -> state IDLE, word_rdy_out=0; fresh word 8'hA5 reads back A5.
//  6 Full FIFO, push+pop edges same cycle -> count stays 8, ovf_out=0, order preserved;
//    with AUTO_ENQUEUE_EN, word reaches FIFO without enqueue_in.

Source files
------------

// File: rtl/serial_word_fifo_pkg.sv
// Shared types and sizing helpers for the bit-serial word FIFO.
package serial_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/serial_word_fifo_if.sv
// Strobe/status bundle between the serial word FIFO and its user.
interface serial_word_fifo_if
  import serial_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  logic                        data_in;
  logic                        write_in;
  logic                        enqueue_in;
  logic                        dequeue_in;
  logic                        status_out;
  logic [WIDTH-1:0]            data_out;
  logic                        word_rdy_out;
  logic                        full_out;
  logic                        empty_out;
  logic [cnt_width(DEPTH)-1:0] count_out;
  logic                        ovf_out;

  modport slave (
    input  data_in, write_in, enqueue_in, dequeue_in,
    output status_out, data_out, word_rdy_out, full_out, empty_out, count_out, ovf_out
  );

  modport master (
    output data_in, write_in, enqueue_in, dequeue_in,
    input  status_out, data_out, word_rdy_out, full_out, empty_out, count_out, ovf_out
  );

endinterface

// File: rtl/serial_word_fifo_edge_sync.sv
// Two-flop synchroniser followed by a single-cycle rising-edge pulse.
module edge_sync (
  input  logic clock_1MHz,
  input  logic rst,
  input  logic strobe,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/serial_word_fifo.sv
// Bit-serial deserialiser feeding a DEPTH-entry circular word FIFO.
// Build option AUTO_ENQUEUE_EN: a completed word is pushed without enqueue_in.
//
// state | meaning
// IDLE  | no bits collected, ready for a new serial word
// SHIFT | collecting bits, bitcnt holds bits received so far
// HOLD  | complete word waiting to be pushed into the FIFO
module serial_word_fifo
  import serial_fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clock_1MHz,
  input logic               rst,
  serial_word_fifo_if.slave bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic wr_pulse, enq_pulse, deq_pulse, enq_trig;
  logic din_s1, din_s2;

  state_t           state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] data_q;
  logic             ovf_q, status_q;
  logic             full, empty, push_req, push_go, pop_go, ovf_set;

  edge_sync u_sync_write (.clock_1MHz(clock_1MHz), .rst(rst), .strobe(bus.write_in),   .pulse(wr_pulse));
  edge_sync u_sync_enq   (.clock_1MHz(clock_1MHz), .rst(rst), .strobe(bus.enqueue_in), .pulse(enq_pulse));
  edge_sync u_sync_deq   (.clock_1MHz(clock_1MHz), .rst(rst), .strobe(bus.dequeue_in), .pulse(deq_pulse));

`ifdef AUTO_ENQUEUE_EN
  logic unused_enq;
  assign unused_enq = enq_pulse;
  assign enq_trig   = 1'b1;
`else
  assign enq_trig   = enq_pulse;
`endif

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign pop_go   = deq_pulse & ~empty;
  assign push_req = (state_q == HOLD) & enq_trig;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign push_go  = push_req & (~full | pop_go);
  assign ovf_set  = push_req & full & ~pop_go;
  assign shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], din_s2} : {din_s2, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    case (state_q)
      IDLE: begin
        bitcnt_d = '0;
        if (wr_pulse) begin
          shreg_d  = shifted;
          bitcnt_d = BW'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (wr_pulse) begin
          shreg_d  = shifted;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BIT_LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (push_go) begin
          state_d  = IDLE;
          bitcnt_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        bitcnt_d = '0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push_go, pop_go})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      status_q <= 1'b1;
      din_s1   <= 1'b0;
      din_s2   <= 1'b0;
    end else begin
      // Data bit follows the same two-flop delay as its write strobe.
      din_s1   <= bus.data_in;
      din_s2   <= din_s1;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      status_q <= (state_d == IDLE) && (count_d != CNT_FULL);
      if (push_go) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_go) begin
        data_q   <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock_1MHz) begin
    if (push_go) mem[wr_ptr_q] <= shreg_q;
  end

  assign bus.status_out   = status_q;
  assign bus.data_out     = data_q;
  assign bus.word_rdy_out = (state_q == HOLD);
  assign bus.full_out     = full;
  assign bus.empty_out    = empty;
  assign bus.count_out    = count_q;
  assign bus.ovf_out      = ovf_q;

endmodule
